seg_scan: RTL and testbench
===========================

# seg_scan

Multiplexed seven-segment scan controller. It consumes the slow scan clock `clk_div` produced by the display clock divider and steps through `NUM_DIGITS` common-anode digits, one per `clk_div` rising edge. Between digits it inserts an all-off guard interval to suppress ghosting. Display data is double-buffered and swapped only at frame boundaries, so digits never tear mid-frame. It sits between the divider and the board's segment and anode pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned per frame (2..8).
- `BLANK_CYCLES`, 4: guard interval in `pixel_clk` cycles (1..255). Must be shorter than the `clk_div` half-period.
- `AN_ACTIVE_LOW`, 1: anode enable polarity.
- `SEG_ACTIVE_LOW`, 1: segment and dp polarity.

Ports:
- `pixel_clk` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-low reset.
- `clk_div` in 1: scan clock from the divider, treated as a level and synchronized internally.
- `data_in` in 4*NUM_DIGITS: hex nibble per digit; digit i = bits [4i+3:4i].
- `dp_in` in NUM_DIGITS: decimal point per digit.
- `blank_in` in NUM_DIGITS: per-digit blank; segments and dp are forced off.
- `load` in 1: 1-cycle strobe that captures `data_in`, `dp_in` and `blank_in` into the pending buffer.
- `an_out` out NUM_DIGITS: digit enables, one-hot active or all inactive.
- `seg_out` out 7: segments; bit0 = a … bit6 = g.
- `dp_out` out 1: decimal point.
- `digit_idx` out 3: index of the current digit.
- `frame_done` out 1: 1-cycle pulse when the scan wraps from the last digit to 0.

## Operation
- **Synchronizer and edge detect:**
  - 3-flop chain s1→s2→s3 on `clk_div`.
  - `tick` = s2 & ~s3.
- **FSM states:**
  - IDLE: reset state; all outputs inactive.
  - BLANK: all anodes inactive; `blank_cnt` counts up to BLANK_CYCLES.
  - SHOW: the anode for `digit_idx` is active, with its decoded segments.
- **Transitions:**
  - IDLE --tick--> BLANK, with `digit_idx` = 0.
  - BLANK --(`blank_cnt` == BLANK_CYCLES-1)--> SHOW.
  - SHOW --tick--> BLANK, with `digit_idx` += 1.
  - A tick arriving while in BLANK is dropped; no queueing.
- **Wrap:**
  - In SHOW with tick and `digit_idx` == NUM_DIGITS-1: `digit_idx` → 0 and `frame_done` = 1 for one cycle.
  - At the same edge, the active buffer updates.
- **Double buffer:**
  - `load` writes the pending buffer and sets `pend_v`.
  - At wrap, the active buffer takes the first applicable of:
    - `data_in` directly, if `load` is high in the same cycle (bypass);
    - otherwise the pending buffer, if `pend_v` is set;
    - otherwise it is unchanged.
  - `pend_v` is cleared at wrap.
  - A second `load` before wrap overwrites the pending buffer; last write wins.
- **Decode:**
  - Standard hex patterns 0–F; lowercase b and d.
  - `blank_in[i]` forces all segments and dp off, but the anode still asserts so scan timing stays uniform.
  - Polarity is applied last, at the output registers.
- **Reset** (`reset`=0, asynchronous):
  - State IDLE; `digit_idx`=0; `blank_cnt`=0; `frame_done`=0; s1..s3=0.
  - Active and pending buffers = 0; `pend_v`=0.
  - `an_out`, `seg_out` and `dp_out` all inactive (all-1 at default polarity).
  - Reset asserted mid-scan forces this state immediately. The first tick after release restarts from digit 0.

## Timing
- All outputs are registered.
- If `clk_div` rises before edge k, `tick` is high in the cycle after edge k+1. The FSM enters BLANK at edge k+2, and `an_out` goes inactive at the same edge.
- SHOW begins exactly BLANK_CYCLES edges after entering BLANK. `an_out` and `seg_out` change together, with no skew cycle.
- `frame_done` rises at the same edge where `digit_idx` becomes 0.
- An active-buffer change first appears on `seg_out` in digit 0's SHOW of the new frame.
- `load` has no effect on the digit currently displayed until the next wrap.

## Structure
- Shared package `seg_pkg` holds:
  - the hex-to-segment constant table (16×7, active-high);
  - state encoding IDLE=2'd0, BLANK=2'd1, SHOW=2'd2;
  - the IDX_W width constant.
- One natural sub-module: `seg_decode`, combinational nibble + blank + dp to active-high 7+1 bits, instantiated once on the muxed digit.
- Synchronizer and FSM live in `seg_scan`.

## Test plan
- **Reset:** hold `reset`=0 for 5 cycles, toggle `clk_div` → `an_out`=8'hFF, `seg_out`=7'h7F, `dp_out`=1; no `frame_done`.
- **Scan sequence:** `load` 32'h76543210, all dp off, `clk_div` period 40 cycles → after the first wrap, `an_out` steps FE, FD, …, 7F. Digit 0 shows `seg_out`=7'h40 ("0"). 4 all-off cycles separate digits. `frame_done` pulses every 8 ticks.
- **Tick latency:** `clk_div` rises between edges → `an_out` goes inactive exactly at the 2nd following edge. It re-activates 4 edges later.
- **Tear-free update:** `load` 32'h11111111 while digit 3 is shown → digits 4–7 keep old values. New data appears from digit 0 after `frame_done`.
- **Simultaneous load and wrap:** `load` 32'hAAAAAAAA coincident with the wrap tick, with older pending 32'h55555555 → frame shows A on all digits (`seg_out`=7'h08); pending discarded.
- **Blank and mid-scan reset:** `blank_in`=8'h04 → digit 2's anode is active with `seg_out`=7'h7F, `dp_out`=1. Then reset at digit 5 → all outputs inactive at once; the next tick resumes at digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// lookup table, scan FSM state encoding and digit-index width.
package seg_pkg;

    // Width of the digit index; covers up to 8 digits.
    localparam int unsigned IDX_W = 3;

    // Width of the inter-digit guard counter; covers BLANK_CYCLES up to 255.
    localparam int unsigned CNT_W = 8;

    // Scan FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    // Active-high segment patterns, bit0 = a ... bit6 = g; entry n is hex digit n.
    // 'b' and 'd' are the lowercase glyphs so they differ from '8' and '0'.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational digit decoder: hex nibble plus decimal point to
// active-high segment bits, with a per-digit blank override.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    // Table lookup, then force everything dark when the digit is blanked.
    always_comb begin
        seg_o = HEX_SEG[nibble_i];
        dp_o  = dp_i;
        if (blank_i) begin
            seg_o = '0;
            dp_o  = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scan controller. Steps through NUM_DIGITS
// common-anode digits on each rising edge of the synchronized scan clock,
// with an all-off guard interval between digits and a double-buffered
// display image that only swaps when the scan wraps back to digit 0.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned BLANK_CYCLES   = 4,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    pixel_clk,
    input  logic                    reset,
    input  logic                    clk_div,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

    // Scan clock synchronizer and rising-edge detect.
    logic s1_q, s2_q, s3_q;
    logic tick;

    // Scan FSM.
    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             frame_done_q, frame_done_d;

    // Double-buffered display image.
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_v_q, pend_v_d;

    // Output path.
    logic [3:0]            sel_nibble;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [6:0]            dec_seg;
    logic                  dec_dp;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Three-flop chain on the asynchronous scan clock level.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_div;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

    // Next-state logic for the scan FSM; ticks seen in BLANK are dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (tick) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
        frame_done_d = wrap;
    end

    // Pending/active buffer update: a load coinciding with the wrap
    // bypasses the pending buffer; otherwise pending is promoted if valid.
    always_comb begin
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_v_d     = pend_v_q;
        if (wrap) begin
            if (load) begin
                act_data_d  = data_in;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
            end else if (pend_v_q) begin
                act_data_d  = pend_data_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_v_d     = 1'b1;
        end
    end

    // Select the digit the FSM is heading into, so anode and segments
    // register together on the edge that enters SHOW.
    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        an_hot     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_nibble = act_data_q[4*i +: 4];
                sel_dp     = act_dp_q[i];
                sel_blank  = act_blank_q[i];
                an_hot[i]  = 1'b1;
            end
        end
    end

    seg_decode u_decode (
        .nibble_i (sel_nibble),
        .dp_i     (sel_dp),
        .blank_i  (sel_blank),
        .seg_o    (dec_seg),
        .dp_o     (dec_dp)
    );

    // Gate outputs off outside SHOW and apply pin polarity last.
    always_comb begin
        if (state_d == SHOW) begin
            an_d  = an_hot ^ AN_OFF;
            seg_d = dec_seg ^ SEG_OFF;
            dp_d  = dec_dp ^ SEG_ACTIVE_LOW;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = SEG_ACTIVE_LOW;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_v_q     <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= SEG_ACTIVE_LOW;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed testbench for seg_scan with default parameters
// (8 digits, 4-cycle guard, active-low anodes and segments).
module tb_seg_scan;

    localparam int unsigned N = 8;

    logic           pixel_clk = 1'b0;
    logic           reset     = 1'b0;
    logic           clk_div   = 1'b0;
    logic           load      = 1'b0;
    logic [4*N-1:0] data_in   = '0;
    logic [N-1:0]   dp_in     = '0;
    logic [N-1:0]   blank_in  = '0;
    logic [N-1:0]   an_out;
    logic [6:0]     seg_out;
    logic           dp_out;
    logic [2:0]     digit_idx;
    logic           frame_done;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;

    seg_scan #(
        .NUM_DIGITS     (8),
        .BLANK_CYCLES   (4),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .clk_div    (clk_div),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Count frame_done pulses, sampled away from the active edge.
    always @(negedge pixel_clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    // One full scan-clock period: 20 cycles high, 20 cycles low.
    task automatic do_tick();
        @(negedge pixel_clk) clk_div = 1'b1;
        repeat (20) @(negedge pixel_clk);
        clk_div = 1'b0;
        repeat (20) @(negedge pixel_clk);
    endtask

    task automatic load_word(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        @(negedge pixel_clk);
        data_in  = d;
        dp_in    = dp;
        blank_in = bl;
        load     = 1'b1;
        @(negedge pixel_clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) begin
            @(negedge pixel_clk);
            clk_div = ~clk_div;
        end
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp %h", an_out, 8'hFF); end
        checks++; if (seg_out !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp %h", seg_out, 7'h7F); end
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp_out); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", digit_idx); end
        clk_div = 1'b0;
        @(negedge pixel_clk) reset = 1'b1;
        repeat (6) @(negedge pixel_clk);
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL idle_an got %h exp %h", an_out, 8'hFF); end
        checks++; if (fd_count !== 0) begin errors++; $display("FAIL reset_fd got %0d exp 0", fd_count); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [8];
        logic [7:0] exp_an;
        exp_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        load_word(32'h76543210, 8'h00, 8'h00);
        // First frame: active buffer still holds the reset image (all "0").
        for (int t = 0; t < 8; t++) begin
            do_tick();
            exp_an = 8'h01 << t;
            exp_an = ~exp_an;
            checks++; if (an_out !== exp_an) begin errors++; $display("FAIL scan0_an d%0d got %h exp %h", t, an_out, exp_an); end
            checks++; if (digit_idx !== 3'(t)) begin errors++; $display("FAIL scan0_idx got %0d exp %0d", digit_idx, t); end
            checks++; if (seg_out !== 7'h40) begin errors++; $display("FAIL scan0_seg d%0d got %h exp %h", t, seg_out, 7'h40); end
        end
        checks++; if (fd_count !== 0) begin errors++; $display("FAIL scan0_fd got %0d exp 0", fd_count); end
        // Second frame: loaded image promoted at the wrap.
        for (int t = 0; t < 8; t++) begin
            do_tick();
            exp_an = 8'h01 << t;
            exp_an = ~exp_an;
            checks++; if (an_out !== exp_an) begin errors++; $display("FAIL scan1_an d%0d got %h exp %h", t, an_out, exp_an); end
            checks++; if (seg_out !== exp_seg[t]) begin errors++; $display("FAIL scan1_seg d%0d got %h exp %h", t, seg_out, exp_seg[t]); end
            checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL scan1_dp d%0d got %b exp 1", t, dp_out); end
        end
        checks++; if (fd_count !== 1) begin errors++; $display("FAIL scan1_fd got %0d exp 1", fd_count); end
    endtask

    task automatic test_latency();
        // Currently showing digit 7; this tick wraps to digit 0.
        @(negedge pixel_clk) clk_div = 1'b1;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        checks++; if (an_out !== 8'h7F) begin errors++; $display("FAIL lat_k1_an got %h exp %h", an_out, 8'h7F); end
        @(negedge pixel_clk);
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL lat_k2_an got %h exp %h", an_out, 8'hFF); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL lat_k2_fd got %b exp 1", frame_done); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL lat_k2_idx got %0d exp 0", digit_idx); end
        @(negedge pixel_clk);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL lat_k3_fd got %b exp 0", frame_done); end
        repeat (2) @(negedge pixel_clk);
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL lat_k5_an got %h exp %h", an_out, 8'hFF); end
        checks++; if (seg_out !== 7'h7F) begin errors++; $display("FAIL lat_k5_seg got %h exp %h", seg_out, 7'h7F); end
        @(negedge pixel_clk);
        checks++; if (an_out !== 8'hFE) begin errors++; $display("FAIL lat_k6_an got %h exp %h", an_out, 8'hFE); end
        checks++; if (seg_out !== 7'h40) begin errors++; $display("FAIL lat_k6_seg got %h exp %h", seg_out, 7'h40); end
        repeat (13) @(negedge pixel_clk);
        clk_div = 1'b0;
        repeat (20) @(negedge pixel_clk);
    endtask

    task automatic test_tear_free();
        logic [6:0] exp_seg [8];
        exp_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        for (int t = 1; t < 4; t++) do_tick();
        checks++; if (seg_out !== exp_seg[3]) begin errors++; $display("FAIL tear_d3_pre got %h exp %h", seg_out, exp_seg[3]); end
        load_word(32'h11111111, 8'h00, 8'h00);
        repeat (3) @(negedge pixel_clk);
        checks++; if (seg_out !== exp_seg[3]) begin errors++; $display("FAIL tear_d3_post got %h exp %h", seg_out, exp_seg[3]); end
        for (int t = 4; t < 8; t++) begin
            do_tick();
            checks++; if (seg_out !== exp_seg[t]) begin errors++; $display("FAIL tear_old d%0d got %h exp %h", t, seg_out, exp_seg[t]); end
        end
        do_tick();
        checks++; if (fd_count !== 3) begin errors++; $display("FAIL tear_fd got %0d exp 3", fd_count); end
        checks++; if (seg_out !== 7'h79) begin errors++; $display("FAIL tear_new_d0 got %h exp %h", seg_out, 7'h79); end
        do_tick();
        checks++; if (seg_out !== 7'h79) begin errors++; $display("FAIL tear_new_d1 got %h exp %h", seg_out, 7'h79); end
    endtask

    task automatic test_back_to_back();
        // Showing digit 1 of the "1" frame; park 5s in pending.
        load_word(32'h55555555, 8'h00, 8'h00);
        for (int t = 2; t < 8; t++) begin
            do_tick();
            checks++; if (seg_out !== 7'h79) begin errors++; $display("FAIL b2b_pre d%0d got %h exp %h", t, seg_out, 7'h79); end
        end
        // Wrap tick with a load landing in the tick cycle.
        @(negedge pixel_clk) clk_div = 1'b1;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        data_in = 32'hAAAAAAAA;
        load    = 1'b1;
        @(negedge pixel_clk);
        load = 1'b0;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_fd got %b exp 1", frame_done); end
        repeat (4) @(negedge pixel_clk);
        checks++; if (an_out !== 8'hFE) begin errors++; $display("FAIL b2b_d0_an got %h exp %h", an_out, 8'hFE); end
        checks++; if (seg_out !== 7'h08) begin errors++; $display("FAIL b2b_d0_seg got %h exp %h", seg_out, 7'h08); end
        repeat (13) @(negedge pixel_clk);
        clk_div = 1'b0;
        repeat (20) @(negedge pixel_clk);
        for (int t = 1; t < 8; t++) begin
            do_tick();
            checks++; if (seg_out !== 7'h08) begin errors++; $display("FAIL b2b_a d%0d got %h exp %h", t, seg_out, 7'h08); end
        end
        do_tick();
        checks++; if (fd_count !== 5) begin errors++; $display("FAIL b2b_fd_count got %0d exp 5", fd_count); end
        checks++; if (seg_out !== 7'h08) begin errors++; $display("FAIL b2b_discard got %h exp %h", seg_out, 7'h08); end
    endtask

    task automatic test_blank_reset();
        load_word(32'h76543210, 8'h0C, 8'h04);
        for (int t = 1; t < 8; t++) do_tick();
        do_tick();
        checks++; if (seg_out !== 7'h40 || dp_out !== 1'b1) begin errors++; $display("FAIL blk_d0 got %h/%b exp 40/1", seg_out, dp_out); end
        do_tick();
        do_tick();
        checks++; if (an_out !== 8'hFB) begin errors++; $display("FAIL blk_d2_an got %h exp %h", an_out, 8'hFB); end
        checks++; if (seg_out !== 7'h7F) begin errors++; $display("FAIL blk_d2_seg got %h exp %h", seg_out, 7'h7F); end
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL blk_d2_dp got %b exp 1", dp_out); end
        do_tick();
        checks++; if (seg_out !== 7'h30 || dp_out !== 1'b0) begin errors++; $display("FAIL blk_d3 got %h/%b exp 30/0", seg_out, dp_out); end
        do_tick();
        do_tick();
        checks++; if (an_out !== 8'hDF) begin errors++; $display("FAIL rst_d5_an got %h exp %h", an_out, 8'hDF); end
        @(negedge pixel_clk) reset = 1'b0;
        #1;
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL rst_mid_an got %h exp %h", an_out, 8'hFF); end
        checks++; if (seg_out !== 7'h7F || dp_out !== 1'b1) begin errors++; $display("FAIL rst_mid_seg got %h/%b exp 7f/1", seg_out, dp_out); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL rst_mid_idx got %0d exp 0", digit_idx); end
        repeat (3) @(negedge pixel_clk);
        reset = 1'b1;
        repeat (3) @(negedge pixel_clk);
        do_tick();
        checks++; if (an_out !== 8'hFE || digit_idx !== 3'd0) begin errors++; $display("FAIL rst_resume got %h/%0d exp fe/0", an_out, digit_idx); end
        do_tick();
        do_tick();
        checks++; if (an_out !== 8'hFB || seg_out !== 7'h40) begin errors++; $display("FAIL rst_d2_cleared got %h/%h exp fb/40", an_out, seg_out); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_latency();
        test_tear_free();
        test_back_to_back();
        test_blank_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
